mem_region_decoder: RTL and testbench

//  Clocked, parametrised Z80 memory-region decoder: splits the address space into 2**SEL_BITS regions.

---
 rtl/mem_dec_pkg.sv | 23 ++
 rtl/mem_wait_counter.sv | 32 +++
 rtl/mem_region_decoder.sv | 134 +++++++++++++
 tb/tb_mem_region_decoder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dec_pkg.sv
// Shared constants, FSM state encoding and one-hot helper for the Z80 memory-region decoder.
package mem_dec_pkg;

    localparam int DEF_ADDR_W   = 16;
    localparam int DEF_SEL_BITS = 3;
    localparam int DEF_WAIT_W   = 3;
    localparam int MAX_SEL_BITS = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    typedef logic [2**MAX_SEL_BITS-1:0] onehot_t;

    // Returns the widest one-hot vector; callers truncate to their own region count.
    function automatic onehot_t region_onehot(input logic [MAX_SEL_BITS-1:0] sel);
        onehot_t oh;
        oh      = '0;
        oh[sel] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-state down-counter: loads the latched wait count, decrements while the access waits.
module mem_wait_counter #(
    parameter int WAIT_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              dec,
    input  logic [WAIT_W-1:0] load_val,
    output logic              zero,
    output logic              last
);

    logic [WAIT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - WAIT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);
    assign last = (cnt_q == WAIT_W'(1));

endmodule

// File: rtl/mem_region_decoder.sv
// Clocked Z80 memory-region decoder with registered one-hot chip selects and per-region wait states.
// Optional write protection is enabled by defining WRITE_PROTECT_EN (adds wp_mask / wp_err).
module mem_region_decoder
    import mem_dec_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int SEL_BITS = DEF_SEL_BITS,
    parameter int WAIT_W   = DEF_WAIT_W,
    localparam int NUM_CS  = 2**SEL_BITS
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mreq_n,
    input  logic                     rfsh_n,
    input  logic                     rd_n,
    input  logic                     wr_n,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [NUM_CS*WAIT_W-1:0] ws_cfg,
`ifdef WRITE_PROTECT_EN
    input  logic [NUM_CS-1:0]        wp_mask,
    output logic                     wp_err,
`endif
    output logic [NUM_CS-1:0]        cs,
    output logic                     wait_n,
    output logic                     busy
);

    logic [1:0]          state_q, state_d;
    logic [NUM_CS-1:0]   cs_q, cs_d;
    logic                wait_n_q, wait_n_d;
    logic [SEL_BITS-1:0] sel;
    logic [WAIT_W-1:0]   ws_sel;
    logic                start, wp_block;
    logic                cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic                unused_addr;

    assign sel         = addr[ADDR_W-1 -: SEL_BITS];
    assign ws_sel      = ws_cfg[sel*WAIT_W +: WAIT_W];
    assign start       = !mreq_n && rfsh_n && (!rd_n || !wr_n);
    assign unused_addr = ^addr[ADDR_W-SEL_BITS-1:0];

`ifdef WRITE_PROTECT_EN
    logic wp_err_q, wp_err_d;

    assign wp_block = !wr_n && wp_mask[sel];

    // Pulse lines up with the edge where cs would have risen.
    always_comb wp_err_d = (state_q == ST_IDLE) && start && wp_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wp_err_q <= 1'b0;
        else        wp_err_q <= wp_err_d;
    end

    assign wp_err = wp_err_q;
`else
    assign wp_block = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cs_d     = cs_q;
        wait_n_d = wait_n_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_load = 1'b1;
                    cs_d     = wp_block ? '0 : NUM_CS'(region_onehot(MAX_SEL_BITS'(sel)));
                    if (ws_sel == '0) begin
                        state_d  = ST_HOLD;
                        wait_n_d = 1'b1;
                    end else begin
                        state_d  = ST_WAIT;
                        wait_n_d = 1'b0;
                    end
                end
            end
            ST_WAIT: begin
                if (mreq_n) begin
                    state_d  = ST_IDLE;
                    cs_d     = '0;
                    wait_n_d = 1'b1;
                end else begin
                    cnt_dec = 1'b1;
                    // Release on the edge where the count reaches zero: ws low cycles total.
                    if (cnt_last || cnt_zero) begin
                        state_d  = ST_HOLD;
                        wait_n_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (mreq_n) begin
                    state_d = ST_IDLE;
                    cs_d    = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cs_d     = '0;
                wait_n_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cs_q     <= '0;
            wait_n_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            cs_q     <= cs_d;
            wait_n_q <= wait_n_d;
        end
    end

    mem_wait_counter #(.WAIT_W(WAIT_W)) u_wait_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (ws_sel),
        .zero     (cnt_zero),
        .last     (cnt_last)
    );

    assign cs     = cs_q;
    assign wait_n = wait_n_q;
    assign busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_region_decoder.sv
// Self-checking bench for mem_region_decoder: directed scenarios plus randomized accesses
// checked against a per-cycle transaction model (region, wait count, hold length).
module tb_mem_region_decoder;

    localparam int ADDR_W = 16;
    localparam int SEL_BITS = 3;
    localparam int WAIT_W = 3;
    localparam int NUM_CS = 8;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     mreq_n = 1'b1;
    logic                     rfsh_n = 1'b1;
    logic                     rd_n = 1'b1;
    logic                     wr_n = 1'b1;
    logic [ADDR_W-1:0]        addr = '0;
    logic [NUM_CS*WAIT_W-1:0] ws_cfg = '0;
    logic [NUM_CS-1:0]        cs;
    logic                     wait_n;
    logic                     busy;
`ifdef WRITE_PROTECT_EN
    logic [NUM_CS-1:0]        wp_mask = '0;
    logic                     wp_err;
`endif

    int passed = 0;
    int total = 0;

    mem_region_decoder #(.ADDR_W(ADDR_W), .SEL_BITS(SEL_BITS), .WAIT_W(WAIT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .mreq_n  (mreq_n),
        .rfsh_n  (rfsh_n),
        .rd_n    (rd_n),
        .wr_n    (wr_n),
        .addr    (addr),
        .ws_cfg  (ws_cfg),
`ifdef WRITE_PROTECT_EN
        .wp_mask (wp_mask),
        .wp_err  (wp_err),
`endif
        .cs      (cs),
        .wait_n  (wait_n),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        mreq_n = 1'b1; rfsh_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_idle();
        step();
        step();
        total++;
        if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL reset: cs=%h wait_n=%b busy=%b want cs=00 wait_n=1 busy=0", cs, wait_n, busy);
        else passed++;
        rst_n = 1'b1;
        step();
        total++;
        if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL post_reset_idle: cs=%h wait_n=%b busy=%b want 00/1/0", cs, wait_n, busy);
        else passed++;
    endtask

    task automatic test_read_no_wait();
        ws_cfg = '0;
        addr = 16'h4000; mreq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({cs, wait_n, busy} !== {8'h04, 1'b1, 1'b1})
                $display("FAIL read_nowait[%0d]: cs=%h wait_n=%b busy=%b want 04/1/1", i, cs, wait_n, busy);
            else passed++;
        end
        bus_idle();
        step();
        total++;
        if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL read_nowait_release: cs=%h wait_n=%b busy=%b want 00/1/0", cs, wait_n, busy);
        else passed++;
    endtask

    task automatic test_write_wait();
        int low_cnt;
        low_cnt = 0;
        ws_cfg = '0;
        ws_cfg[6*WAIT_W +: WAIT_W] = 3'd3;
        addr = 16'hC123; mreq_n = 1'b0; wr_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (!wait_n) low_cnt++;
            total++;
            if ({cs, wait_n, busy} !== {8'h40, (i >= 3), 1'b1})
                $display("FAIL write_wait[%0d]: cs=%h wait_n=%b busy=%b want 40/%0d/1", i, cs, wait_n, busy, (i >= 3));
            else passed++;
        end
        total++;
        if (low_cnt !== 3)
            $display("FAIL write_wait_len: wait_n low %0d cycles want 3", low_cnt);
        else passed++;
        bus_idle();
        step();
        total++;
        if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL write_wait_release: cs=%h wait_n=%b busy=%b want 00/1/0", cs, wait_n, busy);
        else passed++;
    endtask

    task automatic test_refresh();
        addr = 16'h0000; mreq_n = 1'b0; rfsh_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
                $display("FAIL refresh[%0d]: cs=%h wait_n=%b busy=%b want 00/1/0", i, cs, wait_n, busy);
            else passed++;
        end
        bus_idle();
        step();
    endtask

    task automatic test_reset_mid_wait();
        ws_cfg = '0;
        ws_cfg[2*WAIT_W +: WAIT_W] = 3'd5;
        addr = 16'h4000; mreq_n = 1'b0; rd_n = 1'b0;
        // Four edges in: loaded 5 then three decrements leave the counter at 2.
        for (int i = 0; i < 4; i++) step();
        total++;
        if ({cs, wait_n, busy} !== {8'h04, 1'b0, 1'b1})
            $display("FAIL rst_mid_pre: cs=%h wait_n=%b busy=%b want 04/0/1", cs, wait_n, busy);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL rst_mid_async: cs=%h wait_n=%b busy=%b want 00/1/0", cs, wait_n, busy);
        else passed++;
        bus_idle();
        #2 rst_n = 1'b1;
        step();
        total++;
        if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
            $display("FAIL rst_mid_after: cs=%h wait_n=%b busy=%b want 00/1/0", cs, wait_n, busy);
        else passed++;
    endtask

    task automatic test_abort();
        ws_cfg = '0;
        ws_cfg[1*WAIT_W +: WAIT_W] = 3'd5;
        addr = 16'h2000; mreq_n = 1'b0; rd_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({cs, wait_n, busy} !== {8'h02, 1'b0, 1'b1})
                $display("FAIL abort_wait[%0d]: cs=%h wait_n=%b busy=%b want 02/0/1", i, cs, wait_n, busy);
            else passed++;
        end
        bus_idle();
        for (int i = 0; i < 2; i++) begin
            step();
            total++;
            if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
                $display("FAIL abort_idle[%0d]: cs=%h wait_n=%b busy=%b want 00/1/0", i, cs, wait_n, busy);
            else passed++;
        end
    endtask

    // Back-to-back random accesses; each starts on the edge right after the previous release.
    task automatic test_random();
        int ws_tab[NUM_CS];
        int region, hold;
        logic [NUM_CS-1:0] exp_cs;
        logic exp_wait, exp_busy, refresh;
        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < NUM_CS; r++) begin
                ws_tab[r] = $urandom_range(0, 7);
                ws_cfg[r*WAIT_W +: WAIT_W] = WAIT_W'(ws_tab[r]);
            end
            addr    = ADDR_W'($urandom);
            region  = addr / 8192;
            hold    = $urandom_range(1, 10);
            refresh = ($urandom_range(0, 4) == 0);
            mreq_n  = 1'b0;
            rfsh_n  = !refresh;
            if (!refresh && $urandom_range(0, 1) == 1) wr_n = 1'b0;
            else                                       rd_n = 1'b0;
            for (int i = 0; i < hold; i++) begin
                step();
                if (i == 0) begin
                    addr   = ADDR_W'($urandom);
                    ws_cfg = (NUM_CS*WAIT_W)'($urandom);
                end
                exp_cs   = refresh ? 8'h00 : (8'h01 << region);
                exp_wait = refresh ? 1'b1 : (i >= ws_tab[region]);
                exp_busy = !refresh;
                total++;
                if ({cs, wait_n, busy} !== {exp_cs, exp_wait, exp_busy})
                    $display("FAIL rand[%0d.%0d]: cs=%h wait_n=%b busy=%b want %h/%b/%b", n, i, cs, wait_n, busy, exp_cs, exp_wait, exp_busy);
                else passed++;
            end
            bus_idle();
            step();
            total++;
            if ({cs, wait_n, busy} !== {8'h00, 1'b1, 1'b0})
                $display("FAIL rand_release[%0d]: cs=%h wait_n=%b busy=%b want 00/1/0", n, cs, wait_n, busy);
            else passed++;
        end
    endtask

`ifdef WRITE_PROTECT_EN
    task automatic test_write_protect();
        ws_cfg = '0;
        wp_mask = 8'h01;
        addr = 16'h0010; mreq_n = 1'b0; wr_n = 1'b0;
        step();
        total++;
        if ({cs, wp_err, busy} !== {8'h00, 1'b1, 1'b1})
            $display("FAIL wp_write: cs=%h wp_err=%b busy=%b want 00/1/1", cs, wp_err, busy);
        else passed++;
        step();
        total++;
        if ({cs, wp_err} !== {8'h00, 1'b0})
            $display("FAIL wp_pulse_end: cs=%h wp_err=%b want 00/0", cs, wp_err);
        else passed++;
        bus_idle();
        step();
        mreq_n = 1'b0; rd_n = 1'b0;
        step();
        total++;
        if ({cs, wp_err, busy} !== {8'h01, 1'b0, 1'b1})
            $display("FAIL wp_read: cs=%h wp_err=%b busy=%b want 01/0/1", cs, wp_err, busy);
        else passed++;
        bus_idle();
        step();
        wp_mask = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_read_no_wait();
        test_write_wait();
        test_refresh();
        test_reset_mid_wait();
        test_abort();
        test_random();
`ifdef WRITE_PROTECT_EN
        test_write_protect();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
